// File: rtl/ahbl_byte_mailbox_pkg.sv
// Shared constants and types for the AHB-Lite byte mailbox.
// Register offsets, AHB encodings, bit indices, response states.
package ahbl_mbox_pkg;

  localparam logic [7:0] OFF_DATA    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_CTRL    = 8'h08;
  localparam logic [7:0] OFF_SCRATCH = 8'h0C;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;

  localparam int CTRL_RX_IE   = 0;
  localparam int CTRL_TXE_IE  = 1;
  localparam int CTRL_OVF_IE  = 2;
  localparam int CTRL_CLR_OVF = 8;
  localparam int CTRL_FLUSH   = 9;

  typedef enum logic [1:0] {
    RSP_OK,
    RSP_ERR1,
    RSP_ERR2
  } rsp_t;

endpackage

// File: rtl/ahbl_byte_mailbox_if.sv
// AHB-Lite bus bundle between a master/interconnect and the mailbox.
// HREADYIN is the bus-wide ready returned by the interconnect.
interface ahbl_byte_mailbox_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS,
    output HSIZE, HWRITE, HWDATA,
    input  HREADYIN, HREADYOUT,
    input  HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS,
    input  HSIZE, HWRITE, HWDATA,
    input  HREADYIN,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_byte_mailbox_fifo.sv
// First-word-fall-through byte FIFO with flush and occupancy count.
// A push into a full FIFO is taken only alongside a pop.
module mbox_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push & !flush)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ahbl_byte_mailbox.sv
// AHB-Lite MMIO mailbox: byte TX/RX FIFOs, status, control, scratch.
// Zero-wait OKAY responses; errors take the two-cycle ERROR sequence.
module ahbl_byte_mailbox
  import ahbl_mbox_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DEC_BITS   = 8
) (
  input  logic       HCLK,
  input  logic       HRESETN,
  ahbl_byte_mailbox_if.slave bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rsp_t                rsp;
  logic                dp_ok;
  logic                dp_wr;
  logic [DEC_BITS-1:0] dp_off;
  logic [DEC_BITS-1:0] off;
  logic [2:0]          ctrl;
  logic [31:0]         scratch;
  logic                ovf;
  logic [31:0]         status;
  logic [CW-1:0]       tx_cnt, rx_cnt;
  logic                tx_full, tx_empty;
  logic                rx_full, rx_empty;
  logic [7:0]          rx_head;

  logic accept, err, tx_full_nxt;
  logic is_data, is_stat, is_ctrl, is_scr;
  logic d_data, d_stat, d_ctrl, d_scr;
  logic wr_data, rd_data, wr_ctrl, wr_scr;
  logic tx_pop, rx_pop, flush;
  logic ovf_set, ovf_clr;
  logic unused_ok;

  assign unused_ok = ^{bus.HADDR[31:DEC_BITS],
                       bus.HTRANS[0]};

  assign accept  = bus.HSEL & bus.HTRANS[1]
                 & bus.HREADYIN;
  assign off     = bus.HADDR[DEC_BITS-1:0];
  assign is_data = off == DEC_BITS'(OFF_DATA);
  assign is_stat = off == DEC_BITS'(OFF_STATUS);
  assign is_ctrl = off == DEC_BITS'(OFF_CTRL);
  assign is_scr  = off == DEC_BITS'(OFF_SCRATCH);

  assign d_data = dp_off == DEC_BITS'(OFF_DATA);
  assign d_stat = dp_off == DEC_BITS'(OFF_STATUS);
  assign d_ctrl = dp_off == DEC_BITS'(OFF_CTRL);
  assign d_scr  = dp_off == DEC_BITS'(OFF_SCRATCH);

  assign wr_data = dp_ok & dp_wr & d_data;
  assign rd_data = dp_ok & !dp_wr & d_data;
  assign wr_ctrl = dp_ok & dp_wr & d_ctrl;
  assign wr_scr  = dp_ok & dp_wr & d_scr;

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_pop   = rd_data & !rx_empty;
  assign flush    = wr_ctrl & bus.HWDATA[CTRL_FLUSH];
  assign ovf_clr  = wr_ctrl & bus.HWDATA[CTRL_CLR_OVF];
  assign ovf_set  = rx_valid & rx_full & !rx_pop;

  // TX fullness as seen by the upcoming data phase
  assign tx_full_nxt = !flush &
    ((tx_full & !tx_pop) |
     ((tx_cnt == CW'(FIFO_DEPTH - 1))
      & wr_data & !tx_pop));

  assign err = (bus.HADDR[1:0] != 2'b00)
             | !(is_data | is_stat | is_ctrl | is_scr)
             | ((is_ctrl | is_scr)
                & (bus.HSIZE != HSIZE_WORD))
             | (is_stat & bus.HWRITE)
             | (is_data & bus.HWRITE & tx_full_nxt);

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      rsp           <= RSP_OK;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
      dp_ok         <= 1'b0;
      dp_wr         <= 1'b0;
      dp_off        <= '0;
    end else begin
      dp_ok <= 1'b0;
      unique case (rsp)
        RSP_ERR1: begin
          rsp           <= RSP_ERR2;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= 1'b1;
        end
        default: begin
          if (accept & err) begin
            rsp           <= RSP_ERR1;
            bus.HREADYOUT <= 1'b0;
            bus.HRESP     <= 1'b1;
          end else begin
            rsp           <= RSP_OK;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= 1'b0;
            dp_ok         <= accept;
          end
          if (accept) begin
            dp_off <= off;
            dp_wr  <= bus.HWRITE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      ctrl    <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= bus.HWDATA[2:0];
      if (wr_scr)
        scratch <= bus.HWDATA;
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      irq <= (ctrl[CTRL_RX_IE] & !rx_empty)
           | (ctrl[CTRL_TXE_IE] & tx_empty)
           | (ctrl[CTRL_OVF_IE] & ovf);
    end
  end

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_OVF]   = ovf;
    status[15:8]        = 8'(tx_cnt);
    status[23:16]       = 8'(rx_cnt);
  end

  always_comb begin
    bus.HRDATA = '0;
    if (dp_ok & !dp_wr) begin
      unique case (1'b1)
        d_data: bus.HRDATA = rx_empty ? '0
                           : {24'b0, rx_head};
        d_stat: bus.HRDATA = status;
        d_ctrl: bus.HRDATA = {29'b0, ctrl};
        d_scr:  bus.HRDATA = scratch;
        default: bus.HRDATA = '0;
      endcase
    end
  end

  mbox_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk   (HCLK),
    .rst_n (HRESETN),
    .flush (flush),
    .push  (wr_data),
    .pop   (tx_pop),
    .wdata (bus.HWDATA[7:0]),
    .rdata (tx_data),
    .count (tx_cnt),
    .full  (tx_full),
    .empty (tx_empty)
  );

  mbox_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk   (HCLK),
    .rst_n (HRESETN),
    .flush (flush),
    .push  (rx_valid),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .count (rx_cnt),
    .full  (rx_full),
    .empty (rx_empty)
  );
endmodule

// File: tb/tb_ahbl_byte_mailbox.sv
// Self-checking bench for ahbl_byte_mailbox.
// Register table plus hand-built multi-cycle sequences.
module tb_ahbl_byte_mailbox;
  import ahbl_mbox_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    bit          chkrd;
    logic [31:0] rdata;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       irq;

  int n_cmp;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  vec_t        tbl[$];

  ahbl_byte_mailbox_if bus ();
  assign bus.HREADYIN = bus.HREADYOUT;

  ahbl_byte_mailbox #(
    .FIFO_DEPTH (16),
    .DEC_BITS   (8)
  ) dut (
    .HCLK     (clk),
    .HRESETN  (rst_n),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
  endtask

  task automatic addr_ph(input bit wr,
                         input logic [31:0] a,
                         input logic [2:0] sz);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = a;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
  endtask

  function automatic logic [31:0] rsp2();
    return {30'b0, bus.HREADYOUT, bus.HRESP};
  endfunction

  task automatic ahb(input vec_t v, input string nm);
    logic [31:0] e;
    @(posedge clk); #1;
    addr_ph(v.wr, v.addr, v.size);
    if (!v.wr && v.chkrd) exp_q.push_back(v.rdata);
    @(posedge clk); #1;
    idle_bus();
    bus.HWDATA = v.wdata;
    if (v.err) begin
      chk({nm, " err1"}, rsp2(), 32'h1);
      @(posedge clk); #1;
      chk({nm, " err2"}, rsp2(), 32'h3);
    end else begin
      chk({nm, " okay"}, rsp2(), 32'h2);
      if (!v.wr && v.chkrd) begin
        e = exp_q.pop_front();
        chk({nm, " rdata"}, bus.HRDATA, e);
      end
    end
    @(posedge clk);
  endtask

  task automatic wr32(input logic [31:0] a,
                      input logic [31:0] d,
                      input bit err, input string nm);
    vec_t v;
    v = '{1'b1, a, HSIZE_WORD, d, err, 1'b0, 32'h0};
    ahb(v, nm);
  endtask

  task automatic wrb(input logic [7:0] d,
                     input bit err, input string nm);
    vec_t v;
    v = '{1'b1, 32'h0, 3'b000, {24'h0, d},
          err, 1'b0, 32'h0};
    if (!err) tx_q.push_back(d);
    ahb(v, nm);
  endtask

  task automatic rd32(input logic [31:0] a,
                      input logic [31:0] exp,
                      input string nm);
    vec_t v;
    v = '{1'b0, a, HSIZE_WORD, 32'h0,
          1'b0, 1'b1, exp};
    ahb(v, nm);
  endtask

  initial begin
    logic [7:0] b;
    n_cmp  = 0;
    n_fail = 0;
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = HSIZE_WORD;
    bus.HWDATA = '0;
    idle_bus();

    tbl.push_back('{0, 32'h04, 3'd2, 0, 0, 1, 32'h6});
    tbl.push_back('{0, 32'h08, 3'd2, 0, 0, 1, 32'h0});
    tbl.push_back('{0, 32'h0C, 3'd2, 0, 0, 1, 32'h0});
    tbl.push_back('{0, 32'h00, 3'd2, 0, 0, 1, 32'h0});
    tbl.push_back('{0, 32'h10, 3'd2, 0, 1, 0, 32'h0});
    tbl.push_back('{1, 32'h0C, 3'd0, 5, 1, 0, 32'h0});
    tbl.push_back('{0, 32'h02, 3'd2, 0, 1, 0, 32'h0});
    tbl.push_back('{1, 32'h04, 3'd2, 1, 1, 0, 32'h0});
    tbl.push_back('{1, 32'h0C, 3'd2, 32'h12345678,
                    0, 0, 32'h0});
    tbl.push_back('{0, 32'h0C, 3'd2, 0, 0, 1,
                    32'h12345678});
    tbl.push_back('{1, 32'h08, 3'd2, 32'h307,
                    0, 0, 32'h0});
    tbl.push_back('{0, 32'h08, 3'd2, 0, 0, 1, 32'h7});
    tbl.push_back('{1, 32'h08, 3'd2, 0, 0, 0, 32'h0});
    tbl.push_back('{0, 32'h08, 3'd1, 0, 1, 0, 32'h0});
    tbl.push_back('{0, 32'h08, 3'd2, 0, 0, 1, 32'h0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst hready/hresp", rsp2(), 32'h2);
    chk("rst hrdata", bus.HRDATA, 32'h0);
    chk("rst irq", {31'b0, irq}, 32'h0);
    chk("rst tx_valid", {31'b0, tx_valid}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      ahb(tbl[i], $sformatf("tbl%0d", i));

    // TX ordering with consumer stalled, then drained
    wrb(8'h41, 0, "tx w0");
    wrb(8'h42, 0, "tx w1");
    wrb(8'h43, 0, "tx w2");
    rd32(32'h04, 32'h00000304, "tx status3");
    chk("tx head", {24'b0, tx_data}, 32'h41);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b = tx_q.pop_front();
      chk($sformatf("tx valid%0d", i),
          {31'b0, tx_valid}, 32'h1);
      chk($sformatf("tx byte%0d", i),
          {24'b0, tx_data}, {24'b0, b});
      @(posedge clk);
    end
    #1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("tx drained", {31'b0, tx_valid}, 32'h0);

    // TX full: 17th write errors, count holds
    for (int i = 0; i < 16; i++)
      wrb(8'(8'h10 + i), 0, $sformatf("fill%0d", i));
    wrb(8'hEE, 1, "tx overfill");
    rd32(32'h04, 32'h00001005, "tx status full");
    chk("tx full head", {24'b0, tx_data}, 32'h10);
    wr32(32'h08, 32'h200, 0, "flush tx");
    #1;
    chk("flush tx_valid", {31'b0, tx_valid}, 32'h0);
    tx_q.delete();

    // RX overflow
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'(8'hA0 + k);
      if (k < 16) rx_q.push_back(rx_data);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rd32(32'h04, 32'h0010001A, "rx status ovf");
    wr32(32'h08, 32'h4, 0, "ovf ie");
    @(posedge clk); #1;
    chk("ovf irq", {31'b0, irq}, 32'h1);
    wr32(32'h08, 32'h104, 0, "clr ovf");
    @(posedge clk); #1;
    chk("ovf irq cleared", {31'b0, irq}, 32'h0);

    // RX full: read coincident with a new byte
    @(posedge clk); #1;
    addr_ph(1'b0, 32'h00, HSIZE_WORD);
    exp_q.push_back({24'b0, rx_q.pop_front()});
    @(posedge clk); #1;
    idle_bus();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    chk("coinc okay", rsp2(), 32'h2);
    chk("coinc rdata", bus.HRDATA, exp_q.pop_front());
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_q.push_back(8'h5A);
    rd32(32'h04, 32'h0010000A, "coinc status");
    for (int i = 0; i < 2; i++)
      rd32(32'h00, {24'b0, rx_q.pop_front()},
           $sformatf("rx pop%0d", i));
    rd32(32'h04, 32'h000E0002, "rx status14");
    wr32(32'h08, 32'h200, 0, "flush rx");
    rx_q.delete();
    rd32(32'h04, 32'h00000006, "status flushed");

    // RX interrupt rises on a byte, falls after pop
    wr32(32'h08, 32'h1, 0, "rx ie");
    @(posedge clk); #1;
    chk("rx irq idle", {31'b0, irq}, 32'h0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("rx irq set", {31'b0, irq}, 32'h1);
    rd32(32'h00, 32'h77, "rx irq read");
    #1;
    chk("rx irq hold", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    chk("rx irq drop", {31'b0, irq}, 32'h0);

    // Transfer issued during ERROR, then back-to-back
    @(posedge clk); #1;
    addr_ph(1'b0, 32'h10, HSIZE_WORD);
    @(posedge clk); #1;
    chk("b2b err1", rsp2(), 32'h1);
    addr_ph(1'b1, 32'h0C, HSIZE_WORD);
    @(posedge clk); #1;
    chk("b2b err2", rsp2(), 32'h3);
    @(posedge clk); #1;
    chk("b2b wr okay", rsp2(), 32'h2);
    chk("b2b wr hrdata", bus.HRDATA, 32'h0);
    bus.HWDATA = 32'hDEADBEEF;
    addr_ph(1'b0, 32'h0C, HSIZE_WORD);
    @(posedge clk); #1;
    idle_bus();
    chk("b2b rd okay", rsp2(), 32'h2);
    chk("b2b rdata", bus.HRDATA, 32'hDEADBEEF);
    @(posedge clk);

    // Reset in the middle of an ERROR response
    @(posedge clk); #1;
    addr_ph(1'b0, 32'h10, HSIZE_WORD);
    @(posedge clk); #1;
    idle_bus();
    chk("rst err1", rsp2(), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst mid err", rsp2(), 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd32(32'h0C, 32'h0, "post rst scratch");
    rd32(32'h04, 32'h00000006, "post rst status");
    rd32(32'h08, 32'h0, "post rst ctrl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ahbl_byte_mailbox.md
Name: ahbl_byte_mailbox

Overview:
- AHB-Lite slave (responder) on the processor MMIO bus.
- Exposes a byte TX FIFO and a byte RX FIFO toward a serial engine (UART/SPI byte side), plus status, control and scratch registers, with a level interrupt to the processor IRQ.
- Provides zero-wait OKAY responses and a protocol-correct two-cycle ERROR response.

Parameters:
- FIFO_DEPTH, 16: entries per FIFO; power of two, range 2..128.
- DEC_BITS, 8: low HADDR bits decoded. Upper bits are ignored; the interconnect owns HSEL.

Ports:
- HCLK  in  1  clock.
- HRESETN  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  write=1.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYIN  in  1  bus-wide HREADY.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- tx_data  out  8  head of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; no backpressure.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, irq=0, tx_valid=0, both FIFOs empty, CTRL=0, SCRATCH=0, overflow=0.
- Transfer acceptance: a transfer is accepted when HSEL & HTRANS[1] & HREADYIN. Address, write and size are registered at that edge; the data phase follows.
- IDLE/BUSY or unselected transfers get OKAY with zero wait.
- Register map (offset = HADDR[DEC_BITS-1:0]):
  - 0x00 DATA:
    - Write pushes HWDATA[7:0] into TX. Any HSIZE is allowed.
    - Read returns {24'b0, RX head} and pops RX at the end of the data phase.
    - Read when RX is empty returns 0, OKAY, no pop.
  - 0x04 STATUS (RO):
    - [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] rx_overflow.
    - [15:8] tx_count, [23:16] rx_count, zero-extended.
  - 0x08 CTRL (RW, word only):
    - [0] rx_irq_en, [1] tx_empty_irq_en, [2] ovf_irq_en.
    - Write-only strobes: [8] clear overflow, [9] flush both FIFOs. These read as 0.
  - 0x0C SCRATCH: RW, word only, 32 bits.
- ERROR conditions:
  - unmapped offset;
  - HADDR[1:0] != 0;
  - HSIZE != 3'b010 for CTRL or SCRATCH;
  - write to STATUS;
  - DATA write while tx_full. The byte is dropped; FIFO and registers are unchanged.
- ERROR timing: data-phase cycle 1 drives HREADYOUT=0, HRESP=1. Cycle 2 drives HREADYOUT=1, HRESP=1. Return to OKAY afterwards.
- An accepted transfer during ERROR cycle 2 is legal and is decoded normally.
- Read data: HRDATA is driven combinationally in the data phase from the registered address and current state. It is 0 in non-read data phases.
- Write effects: register/FIFO updates happen at the end of the data phase, when HWDATA is valid.
- TX side: first-word fall-through. tx_valid = !tx_empty. A pop occurs on tx_valid & tx_ready.
- RX side:
  - rx_valid pushes if not full, or if full with a pop in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky until cleared).
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - Flush wins over any push or pop in the same cycle.
  - Clear-overflow and a new overflow in the same cycle: set wins.
- irq, registered next cycle: (rx_irq_en & !rx_empty) | (tx_empty_irq_en & tx_empty) | (ovf_irq_en & overflow).
- Counts and pointers: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Reset mid-transfer: state returns to reset values immediately. Any in-flight data phase is abandoned and HREADYOUT=1.

Decomposition:
- Package ahbl_mbox_pkg:
  - register offsets;
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE_WORD;
  - STATUS and CTRL bit indices;
  - response-state enum {RSP_OK, RSP_ERR1, RSP_ERR2}.
- Sub-module mbox_byte_fifo:
  - FWFT sync FIFO with flush, count, full/empty;
  - instantiated twice, once for TX and once for RX.

Test Plan:
- Write 0x41, 0x42, 0x43 to DATA with tx_ready=0 -> STATUS[15:8]=3, tx_data=0x41. Raise tx_ready for 3 cycles -> bytes 0x41, 0x42, 0x43 in order, then tx_empty=1.
- Fill TX with 16 writes; 17th DATA write -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP 1 both cycles), tx_count stays 16.
- Pulse rx_valid 17 times with FIFO_DEPTH=16 and no reads -> rx_full=1, overflow=1. With ovf_irq_en set, irq=1 one cycle later. CTRL write 0x104 clears overflow; irq stays 1 only if other enables apply.
- RX full, DATA read coincident with rx_valid(0x5A) -> read returns the oldest byte, count stays 16, no overflow.
- Read of offset 0x10, byte write to SCRATCH, and word access at 0x02 -> each ERROR. A back-to-back SCRATCH word write of 0xDEADBEEF -> readback 0xDEADBEEF.
- rx_irq_en set, one byte received -> irq=1. DATA read -> irq=0 two cycles later. CTRL flush with TX non-empty -> tx_valid=0 next cycle. Assert HRESETN low mid-ERROR -> HREADYOUT=1, HRESP=0 immediately.
